// File: rtl/camera_pkg.sv
// rtl/camera_pkg.sv - shared types, default dimensions and channel extraction for the frame buffer
package camera_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        STREAM
    } state_t;

    localparam int DEF_WIDTH    = 320;
    localparam int DEF_HEIGHT   = 240;
    localparam int DEF_CHANNELS = 3;
    localparam int DEF_IN_BITS  = 10;
    localparam int DEF_OUT_BITS = 8;

    // Widest packed pixel and widest output word the helper handles.
    localparam int PIXEL_MAX_BITS = 256;
    localparam int WORD_MAX_BITS  = 32;

    // Top out_bits of channel c, right-aligned; the caller truncates to its OUT_BITS.
    function automatic logic [WORD_MAX_BITS-1:0] channel_word(
        input logic [PIXEL_MAX_BITS-1:0] pixel,
        input int                        c,
        input int                        in_bits,
        input int                        out_bits
    );
        return WORD_MAX_BITS'(pixel >> (c * in_bits + in_bits - out_bits));
    endfunction

endpackage

// File: rtl/frame_ram.sv
// rtl/frame_ram.sv - simple dual-port frame RAM, registered read port with enable
module frame_ram #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 30
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port for capture; read register only updates on re so it doubles as the pixel holding register.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/camera_frame_buffer.sv
// rtl/camera_frame_buffer.sv - single-frame snapshot buffer: capture one frame, stream it out per channel
module camera_frame_buffer
    import camera_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HEIGHT   = DEF_HEIGHT,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int IN_BITS  = DEF_IN_BITS,
    parameter int OUT_BITS = DEF_OUT_BITS,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        capture_req,
    input  logic                        continuous,
    input  logic [CHANNELS*IN_BITS-1:0] pixel_in,
    input  logic                        pixel_valid,
    input  logic                        start_frame,
    output logic [OUT_BITS-1:0]         out_data,
    output logic [CH_W-1:0]             out_channel,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_sof,
    output logic                        out_eof,
    output logic                        busy,
    output logic                        short_frame
);

    localparam int N  = WIDTH * HEIGHT;
    localparam int PW = CHANNELS * IN_BITS;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0]   LAST_ADDR = AW'(N - 1);
    localparam logic [CH_W-1:0] LAST_CH   = CH_W'(CHANNELS - 1);

    state_t          state, next_state;
    logic [AW-1:0]   wr_addr, rd_addr, ram_waddr;
    logic            ram_we, ram_re, restart;
    logic [PW-1:0]   rd_data;
    logic [CH_W-1:0] ch;
    logic            pix_valid, pix_first, pix_last, primed;
    logic            load, consume, eof_accept;

    frame_ram #(
        .DEPTH (N),
        .AW    (AW),
        .DW    (PW)
    ) u_frame_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (pixel_in),
        .re    (ram_re),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // The output register takes a new beat whenever it is empty or being drained.
    assign load       = pix_valid && (!out_valid || out_ready);
    assign consume    = load && (ch == LAST_CH);
    assign eof_accept = out_valid && out_ready && out_eof;
    // First read primes the pipe; afterwards the next pixel is fetched as the last channel leaves.
    assign ram_re     = ((state == STREAM) && !primed) || (consume && !pix_last);
    assign busy       = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and capture write control.
    always_comb begin
        next_state = state;
        ram_we     = 1'b0;
        ram_waddr  = wr_addr;
        restart    = 1'b0;
        case (state)
            IDLE: begin
                if (capture_req) begin
                    next_state = ARMED;
                end
            end
            ARMED: begin
                if (pixel_valid && start_frame) begin
                    ram_we     = 1'b1;
                    ram_waddr  = '0;
                    next_state = (N == 1) ? STREAM : CAPTURE;
                end
            end
            CAPTURE: begin
                if (pixel_valid) begin
                    ram_we = 1'b1;
                    if (start_frame && (wr_addr != '0)) begin
                        restart   = 1'b1;
                        ram_waddr = '0;
                    end else if (wr_addr == LAST_ADDR) begin
                        next_state = STREAM;
                    end
                end
            end
            STREAM: begin
                if (eof_accept) begin
                    next_state = continuous ? ARMED : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture address follows the address just written, wrapping at the last pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_addr     <= '0;
            short_frame <= 1'b0;
        end else begin
            short_frame <= restart;
            if (ram_we) begin
                wr_addr <= (ram_waddr == LAST_ADDR) ? '0 : ram_waddr + 1'b1;
            end
        end
    end

    // Read side: tracks which pixel sits in the RAM read register and whether it is first/last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr   <= '0;
            pix_valid <= 1'b0;
            pix_first <= 1'b0;
            pix_last  <= 1'b0;
            primed    <= 1'b0;
        end else begin
            if (ram_re) begin
                rd_addr   <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
                pix_valid <= 1'b1;
                pix_first <= (rd_addr == '0);
                pix_last  <= (rd_addr == LAST_ADDR);
            end else if (consume) begin
                pix_valid <= 1'b0;
            end
            if ((state == STREAM) && !primed) begin
                primed <= 1'b1;
            end else if (eof_accept) begin
                primed <= 1'b0;
            end
        end
    end

    // Output beat register and channel counter; holds steady while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_channel <= '0;
            out_sof     <= 1'b0;
            out_eof     <= 1'b0;
            ch          <= '0;
        end else if (load) begin
            out_valid   <= 1'b1;
            out_data    <= OUT_BITS'(channel_word(PIXEL_MAX_BITS'(rd_data), int'(ch), IN_BITS, OUT_BITS));
            out_channel <= ch;
            out_sof     <= pix_first && (ch == '0);
            out_eof     <= pix_last && (ch == LAST_CH);
            ch          <= (ch == LAST_CH) ? '0 : ch + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_camera_frame_buffer.sv
// tb/tb_camera_frame_buffer.sv - directed self-checking bench for camera_frame_buffer
module tb_camera_frame_buffer;

    logic        clk = 1'b0;
    logic        reset, capture_req, continuous, pixel_valid, start_frame, out_ready, sel;
    logic [29:0] pixel_in;

    logic [7:0] a_data, b_data;
    logic [1:0] a_ch;
    logic       b_ch;
    logic       a_valid, a_sof, a_eof, a_busy, a_short;
    logic       b_valid, b_sof, b_eof, b_busy, b_short;

    wire       o_valid = sel ? b_valid : a_valid;
    wire [7:0] o_data  = sel ? b_data : a_data;
    wire [1:0] o_ch    = sel ? {1'b0, b_ch} : a_ch;
    wire       o_sof   = sel ? b_sof : a_sof;
    wire       o_eof   = sel ? b_eof : a_eof;
    wire       o_busy  = sel ? b_busy : a_busy;
    wire       o_short = sel ? b_short : a_short;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    camera_frame_buffer #(
        .WIDTH  (4),
        .HEIGHT (2)
    ) dut_a (
        .clk         (clk),
        .reset       (reset),
        .capture_req (capture_req & ~sel),
        .continuous  (continuous),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid & ~sel),
        .start_frame (start_frame),
        .out_data    (a_data),
        .out_channel (a_ch),
        .out_valid   (a_valid),
        .out_ready   (out_ready),
        .out_sof     (a_sof),
        .out_eof     (a_eof),
        .busy        (a_busy),
        .short_frame (a_short)
    );

    camera_frame_buffer #(
        .WIDTH    (4),
        .HEIGHT   (2),
        .CHANNELS (1),
        .IN_BITS  (8),
        .OUT_BITS (8)
    ) dut_b (
        .clk         (clk),
        .reset       (reset),
        .capture_req (capture_req & sel),
        .continuous  (continuous),
        .pixel_in    (pixel_in[7:0]),
        .pixel_valid (pixel_valid & sel),
        .start_frame (start_frame),
        .out_data    (b_data),
        .out_channel (b_ch),
        .out_valid   (b_valid),
        .out_ready   (out_ready),
        .out_sof     (b_sof),
        .out_eof     (b_eof),
        .busy        (b_busy),
        .short_frame (b_short)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic [29:0] pix(input int k);
        logic [9:0] c0, c1, c2;
        c0 = 10'(k * 4);
        c1 = 10'((k + 16) * 4);
        c2 = 10'((k + 32) * 4);
        return {c2, c1, c0};
    endfunction

    task automatic send_frame(input int first_k, input int npix, input int gap, output int short_seen);
        short_seen = 0;
        for (int i = 0; i < npix; i++) begin
            pixel_valid = 1'b1;
            start_frame = (i == 0);
            pixel_in    = sel ? 30'(first_k + i) : pix(first_k + i);
            tick();
            if (o_short) short_seen++;
            pixel_valid = 1'b0;
            start_frame = 1'b0;
            for (int g = 0; g < gap; g++) begin
                tick();
                if (o_short) short_seen++;
            end
        end
    endtask

    task automatic pulse_capture();
        capture_req = 1'b1;
        tick();
        capture_req = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!o_valid && n < 20) begin
            tick();
            n++;
        end
        chk(tag, o_valid, 1);
    endtask

    task automatic collect(input int first_k, input int chans, input bit toggle, input int stop_at, input string tag);
        int         n_beats, got, cyc, gaps, stalls, stall_bad;
        logic       prev_stall, ss, se;
        logic [7:0] sd;
        logic [1:0] sc;
        n_beats = 8 * chans;
        got = 0; cyc = 0; gaps = 0; stalls = 0; stall_bad = 0;
        prev_stall = 1'b0; sd = '0; sc = '0; ss = 1'b0; se = 1'b0;
        while (got < n_beats && cyc < 300) begin
            if (stop_at != 0 && got == stop_at) break;
            out_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (prev_stall) begin
                stalls++;
                if (!(o_valid && o_data == sd && o_ch == sc && o_sof == ss && o_eof == se)) stall_bad++;
            end
            prev_stall = o_valid && !out_ready;
            if (prev_stall) begin
                sd = o_data; sc = o_ch; ss = o_sof; se = o_eof;
            end
            if (o_valid && out_ready) begin
                chk($sformatf("%s_data%0d", tag, got), o_data, first_k + got / chans + 16 * (got % chans));
                chk($sformatf("%s_chan%0d", tag, got), o_ch, got % chans);
                chk($sformatf("%s_sof%0d", tag, got), o_sof, got == 0);
                chk($sformatf("%s_eof%0d", tag, got), o_eof, got == n_beats - 1);
                got++;
            end else if (got > 0 && !o_valid) begin
                gaps++;
            end
            tick();
            cyc++;
        end
        chk({tag, "_budget"}, cyc < 300, 1);
        if (stop_at == 0) begin
            out_ready = 1'b1;
            chk({tag, "_beats"}, got, n_beats);
            chk({tag, "_idle_after"}, o_valid, 0);
            if (toggle) begin
                chk({tag, "_stalls_seen"}, stalls > 0, 1);
                chk({tag, "_stall_stable"}, stall_bad, 0);
            end else begin
                chk({tag, "_gaps"}, gaps, 0);
            end
        end
    endtask

    initial begin
        int ss;
        reset = 1'b1; capture_req = 1'b0; continuous = 1'b0; pixel_valid = 1'b0;
        start_frame = 1'b0; out_ready = 1'b1; sel = 1'b0; pixel_in = '0;
        tick();
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_sof", o_sof, 0);
        chk("rst_eof", o_eof, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_short", o_short, 0);
        reset = 1'b0;
        tick();

        // Pixels while idle are ignored.
        send_frame(0, 8, 0, ss);
        tick(); tick(); tick();
        chk("idle_busy", o_busy, 0);
        chk("idle_valid", o_valid, 0);

        // Basic capture and stream.
        pulse_capture();
        chk("armed_busy", o_busy, 1);
        send_frame(0, 8, 0, ss);
        chk("basic_no_short", ss, 0);
        chk("lat_0", o_valid, 0);
        tick();
        chk("lat_1", o_valid, 0);
        tick();
        chk("lat_2", o_valid, 1);
        collect(0, 3, 1'b0, 0, "basic");
        chk("basic_busy_after", o_busy, 0);

        // Backpressure, pixel_valid gaps, capture_req during stream.
        pulse_capture();
        send_frame(0, 8, 1, ss);
        pulse_capture();
        wait_valid("bp_wait");
        collect(0, 3, 1'b1, 0, "bp");
        chk("bp_busy_after", o_busy, 0);

        // Early restart at pixel 5.
        pulse_capture();
        send_frame(0, 5, 0, ss);
        chk("rs_no_short_before", ss, 0);
        send_frame(20, 8, 0, ss);
        chk("rs_short_once", ss, 1);
        wait_valid("rs_wait");
        collect(20, 3, 1'b0, 0, "rs");

        // Continuous mode: two frames, returning to ARMED in between.
        continuous = 1'b1;
        pulse_capture();
        send_frame(0, 8, 0, ss);
        wait_valid("c1_wait");
        collect(0, 3, 1'b0, 0, "c1");
        chk("c1_rearmed", o_busy, 1);
        send_frame(8, 8, 0, ss);
        wait_valid("c2_wait");
        collect(8, 3, 1'b0, 0, "c2");
        chk("c2_rearmed", o_busy, 1);

        // Reset at beat 10 of a third frame.
        send_frame(0, 8, 0, ss);
        wait_valid("c3_wait");
        collect(0, 3, 1'b0, 10, "c3");
        chk("c3_beat10_valid", o_valid, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_data", o_data, 0);
        chk("mid_rst_chan", o_ch, 0);
        chk("mid_rst_sof", o_sof, 0);
        chk("mid_rst_eof", o_eof, 0);
        chk("mid_rst_busy", o_busy, 0);
        continuous = 1'b0;
        out_ready = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        send_frame(0, 8, 0, ss);
        tick(); tick(); tick();
        chk("post_rst_needs_req", o_busy, 0);
        chk("post_rst_no_stream", o_valid, 0);

        // Single-channel, 8-bit variant: no bubbles.
        sel = 1'b1;
        pulse_capture();
        send_frame(0, 8, 0, ss);
        wait_valid("one_wait");
        collect(0, 1, 1'b0, 0, "one");
        chk("one_busy_after", o_busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/camera_frame_buffer.md
# camera_frame_buffer

Parametrised single-frame snapshot buffer for the camera path. It arms on request and captures one complete frame of packed multi-channel pixels from the camera pixel stream into on-chip RAM. It then streams the frame out as one narrow word per channel over a valid/ready interface, with start/end-of-frame markers. It sits between the camera pixel decoder and the downstream consumer (VGA/UART/processing), and is the generalised successor of the fixed 320×240×3 capture block.

## Interface
- `WIDTH`, 320: pixels per line.
- `HEIGHT`, 240: lines per frame; `N = WIDTH*HEIGHT`.
- `CHANNELS`, 3: colour channels packed per input pixel; must be ≥1.
- `IN_BITS`, 10: bits per channel on input.
- `OUT_BITS`, 8: bits per channel on output; must be ≤ IN_BITS.

- `clk` in 1: single clock. Reset is asynchronous and active-high.
- `reset` in 1: asynchronous, active-high reset.
- `capture_req` in 1: one-cycle arm request; honoured only in IDLE.
- `continuous` in 1: 1 = re-arm automatically after each streamed frame.
- `pixel_in` in CHANNELS*IN_BITS: channel c occupies bits [c*IN_BITS +: IN_BITS].
- `pixel_valid` in 1: `pixel_in` valid this cycle.
- `start_frame` in 1: marks the first pixel of a frame; meaningful only together with `pixel_valid`.
- `out_data` out OUT_BITS: channel word equal to the top OUT_BITS bits of the channel.
- `out_channel` out $clog2(max(CHANNELS,2)): index of the channel carried by `out_data`.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: consumer accepts the beat.
- `out_sof` out 1: beat is channel 0 of pixel 0.
- `out_eof` out 1: beat is channel CHANNELS-1 of pixel N-1.
- `busy` out 1: state is not IDLE.
- `short_frame` out 1: one-cycle pulse when a capture is restarted by an early `start_frame`.

## Operation
- States:
  - IDLE: `capture_req` goes to ARMED.
  - ARMED: `start_frame & pixel_valid` writes that pixel to address 0 and goes to CAPTURE with wr_addr=1.
  - CAPTURE: each `pixel_valid` writes at wr_addr and increments it. The write of address N-1 goes to STREAM.
  - STREAM: reads addresses 0..N-1 and emits CHANNELS beats per pixel, channel 0 first. Acceptance of the `out_eof` beat goes to ARMED if `continuous`, otherwise IDLE.
- A `start_frame & pixel_valid` in CAPTURE while wr_addr≠0 restarts the capture: that pixel is written to address 0, wr_addr=1, and `short_frame` pulses.
- Pixels and `start_frame` are ignored in IDLE and STREAM; there is no overwrite while streaming.
- `capture_req` is ignored when not in IDLE. Clearing `continuous` takes effect at the next end of stream.
- Beat handshake: transfer when `out_valid & out_ready`. While `out_valid & !out_ready`, `out_data`, `out_channel`, `out_sof` and `out_eof` must hold stable. `out_valid` never drops without a transfer.
- Channel extraction: `out_data = pixel[c*IN_BITS + IN_BITS-1 -: OUT_BITS]` (truncation, no rounding).
- Counters are $clog2(N) bits wide for addresses and $clog2(CHANNELS) bits for the channel index. Both wrap to 0 exactly at N / CHANNELS, never by overflow.

## Timing
- Reset: state IDLE, all outputs 0, counters 0. RAM contents are not reset. A reset mid-capture or mid-stream aborts immediately, and the next frame requires a new `capture_req`.
- Capture latency: a pixel is written on the cycle after it is presented.
- Stream start: the first `out_valid` rises 2 cycles after the cycle in which address N-1 is written (one cycle for the state change, one for the RAM read).
- Throughput: with `out_ready` held high, one beat per cycle with no bubbles, including at pixel boundaries and for CHANNELS=1. This requires prefetch of the next pixel plus a one-entry holding register.
- Frame length: a streamed frame is exactly N*CHANNELS beats.
- Simultaneous events: `capture_req` in the same cycle as reset is lost.

## Structure
- Package `camera_pkg` holds:
  - `state_t` enum (IDLE, ARMED, CAPTURE, STREAM);
  - default dimension constants (320, 240, 3, 10, 8);
  - the function returning channel c of a packed pixel.
- Sub-module `frame_ram`: simple dual-port RAM (write port for capture, registered read port for streaming), depth N, width CHANNELS*IN_BITS, 1-cycle read latency, inferred as M10K.
- Control FSM, counters and output skid live in the top.

## Test plan
- **Basic capture and stream.** WIDTH=4, HEIGHT=2, defaults. `capture_req`, then 8 pixels with channel values {c=k, k+16, k+32}<<2 for k=0..7, `out_ready`=1.
  - Expect 24 beats k, k+16, k+32 in order.
  - `out_sof` on beat 0, `out_eof` on beat 23, no gaps.
  - First beat 2 cycles after the last write; `busy`=0 afterwards.
- **Backpressure.** Same frame with `out_ready` toggling 1,0,0,1…
  - Data stable during stalls; the sequence is identical.
  - Exactly 24 transfers.
- **Early restart.** `start_frame` at pixel 5 of 8.
  - `short_frame` pulses once.
  - The stream contains the 8 pixels starting at the restart pixel.
- **Ignored inputs.**
  - Pixels in IDLE produce nothing.
  - `pixel_valid` gaps during CAPTURE are tolerated.
  - `capture_req` during STREAM is ignored.
- **Continuous mode and reset.**
  - `continuous`=1: two frames stream back-to-back, with a return to ARMED between them.
  - Reset asserted mid-stream at beat 10: all outputs 0 in the same cycle.
- **CHANNELS=1, OUT_BITS=IN_BITS=8.** Stream of 8 beats with no bubbles under continuous `out_ready`.
